loadable_mem: RTL

LOADABLE_MEM -- requirements
Module: loadable_mem

---
 rtl/loadable_mem.sv | 113 +++++++++++
 1 files changed

// File: rtl/loadable_mem.sv
// Word memory with a CPU read/write port and a streaming program loader that owns the write port while busy.
// Optional macro LOADABLE_MEM_RDREG_EN registers dout for a 1-cycle read latency.
module loadable_mem #(
    parameter int                DATA_W    = 8,
    parameter int                ADDR_W    = 16,
    parameter int                DEPTH     = 65536,
    parameter logic [ADDR_W-1:0] TEST_ADDR = ADDR_W'(16'hFFFE)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] din,
    input  logic              we,
    output logic [DATA_W-1:0] dout,
    output logic [DATA_W-1:0] test_mem,
    input  logic              ld_start,
    input  logic [ADDR_W-1:0] ld_base,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_last,
    output logic              ld_ready,
    output logic              ld_busy,
    output logic              ld_done,
    output logic              ld_err
);

    localparam int                IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_L  = ADDR_W'(DEPTH - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]        state;
    logic [ADDR_W-1:0] ptr;
    logic              err;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_data;

    logic accept, ptr_end, ptr_ok, addr_ok, cpu_we;

    assign accept  = (state == LOAD) && ld_valid;
    assign ptr_end = (ptr >= LAST_L);
    assign ptr_ok  = ({1'b0, ptr} < DEPTH_L);
    assign addr_ok = ({1'b0, addr} < DEPTH_L);
    assign cpu_we  = we && (state != LOAD) && addr_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            ptr   <= '0;
            err   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (ld_start) begin
                    state <= LOAD;
                    ptr   <= ld_base;
                    err   <= 1'b0;
                end
                LOAD: if (accept) begin
                    // The pointer parks on the last word rather than wrapping.
                    if (!ptr_end)
                        ptr <= ptr + 1'b1;
                    if (ld_last)
                        state <= DONE;
                    else if (ptr_end) begin
                        err   <= 1'b1;
                        state <= IDLE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Contents survive reset so a partial load is kept.
    always_ff @(posedge clk) begin
        if (accept && ptr_ok)
            mem[ptr[IDX_W-1:0]] <= ld_data;
        else if (cpu_we)
            mem[addr[IDX_W-1:0]] <= din;
    end

    assign rd_data = addr_ok ? mem[addr[IDX_W-1:0]] : '0;

`ifdef LOADABLE_MEM_RDREG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            dout <= '0;
        else
            dout <= rd_data;
    end
`else
    assign dout = rd_data;
`endif

    generate
        if ({1'b0, TEST_ADDR} >= DEPTH_L) begin : g_test_none
            assign test_mem = '0;
        end else begin : g_test_mem
            localparam logic [IDX_W-1:0] TEST_IDX = TEST_ADDR[IDX_W-1:0];
            assign test_mem = mem[TEST_IDX];
        end
    endgenerate

    assign ld_ready = (state == LOAD);
    assign ld_busy  = (state == LOAD);
    assign ld_done  = (state == DONE);
    assign ld_err   = err;

endmodule
